dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
- Data-memory responder for the pipeline's EX/MEM stage. Accepts load, store and swap requests and drives a synchronous single-port SRAM.
- Returns aligned, extended load data with a one-cycle valid pulse.
- Holds `mem_busy` high while an access is in flight, so the pipeline stall logic freezes the stages behind it.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data/word width; fixed at 32 in this revision.
- READ_LAT, 1, SRAM read latency in cycles from `sram_re` to valid `sram_rdata`; legal range 1..3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- memread_ex_mem  in  1  load request
- memwrite_ex_mem  in  1  store request; both request inputs high means swap
- addr_ex_mem  in  ADDR_W  byte address
- wdata_ex_mem  in  32  store data, right-aligned
- size_ex_mem  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- unsigned_ex_mem  in  1  zero-extend loads when 1, sign-extend when 0
- mem_busy  out  1  access in flight
- rvalid  out  1  one-cycle pulse, `rdata` valid
- rdata  out  32  extended load/swap result
- sram_addr  out  ADDR_W-2  word address
- sram_re  out  1  read strobe
- sram_we  out  1  write strobe
- sram_be  out  4  byte enables
- sram_wdata  out  32  lane-positioned write data
- sram_rdata  in  32  SRAM read data
- misalign_err  out  1  see Optional Feature; tied 0 when the feature is compiled out

Behaviour:
- Reset (`rst_n`=0 at a rising edge):
  - State becomes IDLE; the latency counter clears.
  - All outputs are 0, including `sram_we`; an in-flight write is abandoned.
  - Reset overrides any state, including mid-operation.
- Request capture: the controller samples requests only in IDLE. Address, data, size, unsigned and kind are registered at acceptance edge T. Requests seen while not IDLE are ignored; the pipeline must hold them.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
  - IDLE, load or swap → RD_ISSUE.
  - IDLE, store → WR_ISSUE.
  - RD_ISSUE: `sram_re`=1 for exactly one cycle (T+1); latency counter loads READ_LAT-1. → RD_WAIT.
  - RD_WAIT: counter decrements each cycle. When the counter is 0, `sram_rdata` is captured.
    - Swap → WR_ISSUE.
    - Load → RESP.
  - WR_ISSUE: `sram_we`=1 for exactly one cycle; `sram_be` and `sram_wdata` come from size and addr[1:0]. → RESP.
  - RESP: `rvalid`=1 for one cycle; `rdata` holds the extracted data for load and swap, and 0 for store. → IDLE.
- Timing: `mem_busy` is high from T+1 through the RESP cycle inclusive, and low in IDLE.
  - Load latency: T to `rvalid` is READ_LAT+2 cycles.
  - Store latency: 2 cycles.
  - Swap latency: READ_LAT+3 cycles.
- Byte enables:
  - Byte: bit addr[1:0].
  - Half: 0011 when addr[1]=0, else 1100.
  - Word: 1111.
- Write data lanes: store data is replicated into the selected lanes (byte: `{4{b}}`; half: `{2{h}}`).
- Load extraction: select the lane by addr[1:0] (half by addr[1]), then zero- or sign-extend from bit 7 or bit 15 to 32 bits.
- Swap: returns the old word, extracted by size and sign, and writes the new data in the same lanes. No other request can interleave, so the swap is atomic.
- Misaligned accesses (half with addr[0]=1; word with addr[1:0]≠0) without the Optional Feature:
  - The address is forced to lane alignment by ignoring the low bits.
  - No error is raised.
- `rdata` is stable only during `rvalid`; otherwise it holds its last value.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Compiled in: a misaligned request accepted in IDLE skips all SRAM activity and goes straight to RESP. In RESP:
  - `misalign_err`=1 for that one cycle, together with `rvalid`;
  - `rdata`=0;
  - `mem_busy` is high for exactly 1 cycle.
- Compiled out: `misalign_err` is constant 0, and misaligned accesses are aligned silently as described above.

Decomposition:
- Shared package dmem_pkg:
  - enum `mem_size_t` (BYTE, HALF, WORD);
  - enum `dmem_state_t`;
  - function `be_gen(size, addr_lo)`;
  - function `load_extract(word, size, addr_lo, uns)`.
- One sub-module, dmem_lane_align: purely combinational. It produces `sram_be` and `sram_wdata`, and the extracted load data; it is reused by the verification reference model.

Test Plan:
- Word load: SRAM word 0x40 = 0xDEADBEEF, load word at 0x40 with READ_LAT=1 → `sram_re` at T+1 with `sram_addr`=0x10; `rvalid` at T+3 with `rdata`=0xDEADBEEF; `mem_busy` high T+1..T+3.
- Signed byte load at 0x43 of the same word → `rdata`=0xFFFFFFDE. The unsigned version → 0x000000DE. Half at 0x40, signed → 0xFFFFBEEF.
- Byte store of wdata 0x000000A5 at 0x22 → one `sram_we` cycle with `sram_be`=0100 and `sram_wdata`=0xA5A5A5A5; `rvalid` at T+2 with `rdata`=0.
- Swap at 0x40, word, wdata 0x12345678, READ_LAT=2 → `sram_re` at T+1, `sram_we` at T+4, `rvalid` at T+5 with `rdata`=0xDEADBEEF; memory then reads 0x12345678. Requests pulsed during busy produce no SRAM activity.
- Reset mid-operation: assert `rst_n`=0 in the RD_WAIT cycle of a swap → no `sram_we` ever asserted; all outputs 0 next cycle; a load issued after reset completes normally.
- With DMEM_MISALIGN_TRAP_EN: word load at 0x41 → no `sram_re`; `rvalid`=1 and `misalign_err`=1 at T+1, `rdata`=0. Without the macro: same request returns the word at 0x40.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory controller (dmem_ctrl).
package dmem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        RESP
    } dmem_state_t;

    // The reserved size code 2'b11 falls into the word arm of every helper.
    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            BYTE:    be_gen = 4'b0001 << addr_lo;
            HALF:    be_gen = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] addr_lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            BYTE:    load_extract = {{24{~uns & b[7]}}, b};
            HALF:    load_extract = {{16{~uns & h[15]}}, h};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            BYTE:    is_misaligned = 1'b0;
            HALF:    is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables, replicated write lanes and extended load data.
module dmem_lane_align import dmem_pkg::*; (
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    assign be        = be_gen(size, addr_lo);
    assign rdata_ext = load_extract(rword, size, addr_lo, uns);

    always_comb begin
        case (size)
            BYTE:    wdata_lanes = {4{wdata[7:0]}};
            HALF:    wdata_lanes = {2{wdata[15:0]}};
            default: wdata_lanes = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// EX/MEM data-memory responder driving a synchronous single-port SRAM.
// Optional misaligned-access trap compiled in with DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl import dmem_pkg::*; #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memread_ex_mem,
    input  logic              memwrite_ex_mem,
    input  logic [ADDR_W-1:0] addr_ex_mem,
    input  logic [DATA_W-1:0] wdata_ex_mem,
    input  logic [1:0]        size_ex_mem,
    input  logic              unsigned_ex_mem,
    output logic              mem_busy,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-3:0] sram_addr,
    output logic              sram_re,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              misalign_err
);

    // Handshake: a request is taken on any rising edge where mem_busy is low and
    // memread/memwrite is high; the pipeline holds it until mem_busy drops.
    // rvalid is a single-cycle response with no back-pressure.
    localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

    dmem_state_t       state;
    logic [1:0]        lat_cnt;
    logic [1:0]        size_q, addr_lo_q;
    logic              uns_q, swap_q, err_q;
    logic [DATA_W-1:0] wdata_q, old_q;

    logic [1:0]        al_size, al_addr_lo;
    logic              al_uns;
    logic [DATA_W-1:0] al_wdata, al_wdata_lanes, al_rdata_ext;
    logic [3:0]        al_be;

    // A store leaves IDLE with its strobes already registered, so the aligner
    // sees the live request in IDLE and the captured one afterwards.
    always_comb begin
        if (state == IDLE) begin
            al_size    = size_ex_mem;
            al_addr_lo = addr_ex_mem[1:0];
            al_uns     = unsigned_ex_mem;
            al_wdata   = wdata_ex_mem;
        end else begin
            al_size    = size_q;
            al_addr_lo = addr_lo_q;
            al_uns     = uns_q;
            al_wdata   = wdata_q;
        end
    end

    dmem_lane_align u_align (
        .size        (al_size),
        .addr_lo     (al_addr_lo),
        .uns         (al_uns),
        .wdata       (al_wdata),
        .rword       (sram_rdata),
        .be          (al_be),
        .wdata_lanes (al_wdata_lanes),
        .rdata_ext   (al_rdata_ext)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign_req;
    assign misalign_req = is_misaligned(size_ex_mem, addr_ex_mem[1:0]);
`endif

    assign misalign_err = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            size_q     <= '0;
            addr_lo_q  <= '0;
            uns_q      <= 1'b0;
            swap_q     <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            old_q      <= '0;
            mem_busy   <= 1'b0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            sram_addr  <= '0;
            sram_re    <= 1'b0;
            sram_we    <= 1'b0;
            sram_be    <= '0;
            sram_wdata <= '0;
        end else begin
            sram_re    <= 1'b0;
            sram_we    <= 1'b0;
            sram_be    <= '0;
            sram_wdata <= '0;
            rvalid     <= 1'b0;
            err_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (memread_ex_mem || memwrite_ex_mem) begin
                        size_q    <= size_ex_mem;
                        addr_lo_q <= addr_ex_mem[1:0];
                        uns_q     <= unsigned_ex_mem;
                        wdata_q   <= wdata_ex_mem;
                        swap_q    <= memread_ex_mem & memwrite_ex_mem;
                        sram_addr <= addr_ex_mem[ADDR_W-1:2];
                        mem_busy  <= 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
                        if (misalign_req) begin
                            state  <= RESP;
                            rvalid <= 1'b1;
                            rdata  <= '0;
                            err_q  <= 1'b1;
                        end else
`endif
                        if (memread_ex_mem) begin
                            state   <= RD_ISSUE;
                            sram_re <= 1'b1;
                        end else begin
                            state      <= WR_ISSUE;
                            sram_we    <= 1'b1;
                            sram_be    <= al_be;
                            sram_wdata <= al_wdata_lanes;
                        end
                    end
                end
                RD_ISSUE: begin
                    lat_cnt <= LAT_INIT;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        if (swap_q) begin
                            old_q      <= al_rdata_ext;
                            state      <= WR_ISSUE;
                            sram_we    <= 1'b1;
                            sram_be    <= al_be;
                            sram_wdata <= al_wdata_lanes;
                        end else begin
                            state  <= RESP;
                            rvalid <= 1'b1;
                            rdata  <= al_rdata_ext;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                WR_ISSUE: begin
                    state  <= RESP;
                    rvalid <= 1'b1;
                    rdata  <= swap_q ? old_q : '0;
                end
                RESP: begin
                    state    <= IDLE;
                    mem_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
